// File: rtl/slot_ctrl_if.sv
// slot_ctrl_if: slot timing, register and radio-control bundle of the slot scheduler
`timescale 1ns/1ps
interface slot_ctrl_if #(parameter int WIN_W = 6);
   logic             p_1us;
   logic             tslot_p;
   logic [27:0]      BTCLK;
   logic [9:0]       counter_1us;
   logic             corre_sync_p;
   logic             rx_done_p;
   logic             regi_link_en;
   logic             regi_is_master;
   logic [WIN_W-1:0] regi_win_us;
   logic [8:0]       regi_tx_len_us;
   logic             tx_req;
   logic             tx_en;
   logic             rx_en;
   logic             corr_win_open;
   logic             sync_found_p;
   logic             rx_timeout_p;
   logic             rx_abort_p;
   logic             tx_slot;
   modport master (
      output p_1us, tslot_p, BTCLK, counter_1us, corre_sync_p, rx_done_p,
             regi_link_en, regi_is_master, regi_win_us, regi_tx_len_us, tx_req,
      input  tx_en, rx_en, corr_win_open, sync_found_p, rx_timeout_p, rx_abort_p, tx_slot
   );
   modport slave (
      input  p_1us, tslot_p, BTCLK, counter_1us, corre_sync_p, rx_done_p,
             regi_link_en, regi_is_master, regi_win_us, regi_tx_len_us, tx_req,
      output tx_en, rx_en, corr_win_open, sync_found_p, rx_timeout_p, rx_abort_p, tx_slot
   );
endinterface

// File: rtl/slot_ctrl.sv
// slot_ctrl: per-slot TX/RX scheduler with sync search window and multi-slot RX abort
`timescale 1ns/1ps
module slot_ctrl #(
   parameter int SYNC_END_US = 68,
   parameter int MAX_SLOTS   = 5
) (
   input logic        clk_6M,
   input logic        rstz,
   slot_ctrl_if.slave s
);
   localparam int SW = $clog2(MAX_SLOTS + 2);
   typedef enum logic [2:0] {IDLE, DECIDE, TX, RX_SEARCH, RX_ACTIVE} state_t;
   state_t        st, nxt;
   logic [8:0]    us_cnt;
   logic [SW-1:0] slot_cnt;
   logic          par, win_end, sync_d, to_d, ab_d;
   logic          unused_bt;
   assign unused_bt = ^{s.BTCLK[27:2], s.BTCLK[0]};
   assign par = s.BTCLK[1] ^ s.regi_is_master;
   // 11-bit sum keeps a wide window from aliasing onto a small counter value
   assign win_end = s.p_1us && ({1'b0, s.counter_1us} == 11'(SYNC_END_US) + 11'(s.regi_win_us));
   always_comb begin
      nxt = st;
      sync_d = 1'b0;
      to_d = 1'b0;
      ab_d = 1'b0;
      if (!s.regi_link_en) nxt = IDLE;
      else case (st)
         IDLE:   nxt = s.tslot_p ? DECIDE : IDLE;
         DECIDE: nxt = !par ? RX_SEARCH : (s.tx_req && s.regi_tx_len_us != 9'd0) ? TX : IDLE;
         TX:     nxt = s.tslot_p ? DECIDE : (us_cnt == s.regi_tx_len_us) ? IDLE : TX;
         RX_SEARCH: begin
            sync_d = s.corre_sync_p;
            to_d = !s.corre_sync_p && (s.tslot_p || win_end);
            nxt = s.corre_sync_p ? RX_ACTIVE : s.tslot_p ? DECIDE : win_end ? IDLE : RX_SEARCH;
         end
         RX_ACTIVE: begin
            ab_d = !s.rx_done_p && s.tslot_p && slot_cnt == SW'(MAX_SLOTS);
            nxt = s.rx_done_p ? IDLE : ab_d ? DECIDE : RX_ACTIVE;
         end
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk_6M or negedge rstz)
      if (!rstz) begin
         st <= IDLE;
         us_cnt <= '0;
         slot_cnt <= '0;
         s.tx_slot <= 1'b0;
         s.tx_en <= 1'b0;
         s.rx_en <= 1'b0;
         s.corr_win_open <= 1'b0;
         s.sync_found_p <= 1'b0;
         s.rx_timeout_p <= 1'b0;
         s.rx_abort_p <= 1'b0;
      end else begin
         st <= nxt;
         us_cnt <= (st != TX) ? '0 : s.p_1us ? us_cnt + 9'd1 : us_cnt;
         slot_cnt <= (st != RX_ACTIVE) ? SW'(1) : s.tslot_p ? slot_cnt + SW'(1) : slot_cnt;
         s.tx_slot <= (st == DECIDE) ? par : s.tx_slot;
         s.tx_en <= nxt == TX;
         s.rx_en <= nxt == RX_SEARCH || nxt == RX_ACTIVE;
         s.corr_win_open <= nxt == RX_SEARCH;
         s.sync_found_p <= sync_d;
         s.rx_timeout_p <= to_d;
         s.rx_abort_p <= ab_d;
      end
endmodule

// File: tb/tb_slot_ctrl.sv
// tb_slot_ctrl: decision vectors plus multi-cycle slot sequences; pulses checked through a scoreboard
`timescale 1ns/1ps
module tb_slot_ctrl;
   logic clk_6M = 1'b0;
   logic rstz = 1'b0;
   always #83 clk_6M = ~clk_6M;
   slot_ctrl_if #(.WIN_W(6)) i ();
   slot_ctrl #(.SYNC_END_US(68), .MAX_SLOTS(5)) dut (.clk_6M(clk_6M), .rstz(rstz), .s(i));
   typedef struct {logic [2:0] pl; int cyc;} ev_t;
   typedef struct {logic m, b1, req; logic [8:0] len; logic ts, tx, rx;} vec_t;
   localparam logic [2:0] SY = 3'b001, TO = 3'b010, AB = 3'b100;
   ev_t         q[$];
   vec_t        tv[8];
   int          n_chk = 0, n_err = 0, cyc = 0, us = 0, ph = 0, n_us, gap;
   logic [27:0] bt = '0;
   logic        pend = 1'b0, hit;
   logic [2:0]  pl_m;
   ev_t         e_m;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask
   function automatic logic [6:0] outs();
      return {i.tx_slot, i.tx_en, i.rx_en, i.corr_win_open, i.sync_found_p, i.rx_timeout_p, i.rx_abort_p};
   endfunction
   // slot timer model: 6 clocks per us, 625 us per slot, BTCLK advances one slot at the wrap
   task automatic drive(input logic sy = 1'b0, input logic dn = 1'b0);
      @(negedge clk_6M);
      cyc++;
      if (pend) begin
         if (us == 624) begin
            us = 0;
            bt += 28'd2;
         end else us++;
      end
      ph = (ph == 5) ? 0 : ph + 1;
      pend = (ph == 5);
      i.p_1us = pend;
      i.tslot_p = pend && us == 624;
      i.counter_1us = 10'(us);
      i.BTCLK = bt;
      i.corre_sync_p = sy;
      i.rx_done_p = dn;
   endtask
   task automatic settle();
      @(posedge clk_6M);
      #1;
   endtask
   task automatic step();
      drive();
      settle();
   endtask
   task automatic jump(input int u, input int p);
      us = u;
      ph = p;
      pend = 1'b0;
   endtask
   task automatic exp_p(input logic [2:0] pl);
      ev_t e;
      e.pl = pl;
      e.cyc = cyc;
      q.push_back(e);
   endtask
   task automatic run_to(input int u);
      for (int c = 0; c < 5000 && us != u; c++) step();
   endtask
   task automatic enter(input logic m, input logic b1);
      i.regi_is_master = m;
      bt = b1 ? 28'd0 : 28'd2;
      jump(624, 4);
      step();
      chk("decide_quiet", {i.tx_en, i.rx_en, i.corr_win_open}, 3'b000);
      step();
   endtask
   initial begin : mon
      forever begin
         @(posedge clk_6M);
         #1;
         pl_m = {i.rx_abort_p, i.rx_timeout_p, i.sync_found_p};
         if (i.tx_en === 1'b1 && i.rx_en === 1'b1) begin
            n_chk++;
            n_err++;
            $display("FAIL tx_rx_excl: got tx_en=1 rx_en=1 at cycle %0d, want not both", cyc);
         end
         if (pl_m != 3'b000 || (q.size() > 0 && q[0].cyc == cyc)) begin
            n_chk++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL pulse: got %b at cycle %0d, want none", pl_m, cyc);
            end else begin
               e_m = q.pop_front();
               if (pl_m !== e_m.pl || cyc != e_m.cyc) begin
                  n_err++;
                  $display("FAIL pulse: got %b at cycle %0d, want %b at cycle %0d", pl_m, cyc, e_m.pl, e_m.cyc);
               end
            end
         end
      end
   end
   initial begin : wdog
      #(60000 * 166);
      $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
      $fatal(1);
   end
   initial begin
      tv[0] = '{1'b1, 1'b0, 1'b1, 9'd10, 1'b1, 1'b1, 1'b0};
      tv[1] = '{1'b1, 1'b1, 1'b1, 9'd10, 1'b0, 1'b0, 1'b1};
      tv[2] = '{1'b0, 1'b1, 1'b1, 9'd10, 1'b1, 1'b1, 1'b0};
      tv[3] = '{1'b0, 1'b0, 1'b1, 9'd10, 1'b0, 1'b0, 1'b1};
      tv[4] = '{1'b1, 1'b0, 1'b0, 9'd10, 1'b1, 1'b0, 1'b0};
      tv[5] = '{1'b1, 1'b0, 1'b1, 9'd0,  1'b1, 1'b0, 1'b0};
      tv[6] = '{1'b0, 1'b1, 1'b0, 9'd10, 1'b1, 1'b0, 1'b0};
      tv[7] = '{1'b0, 1'b0, 1'b0, 9'd0,  1'b0, 1'b0, 1'b1};
      i.regi_link_en = 1'b0;
      i.regi_is_master = 1'b0;
      i.regi_win_us = 6'd8;
      i.regi_tx_len_us = 9'd0;
      i.tx_req = 1'b0;
      repeat (3) step();
      chk("reset", outs(), 7'd0);
      rstz = 1'b1;
      i.regi_link_en = 1'b1;
      step();
      foreach (tv[k]) begin
         i.tx_req = tv[k].req;
         i.regi_tx_len_us = tv[k].len;
         enter(tv[k].m, tv[k].b1);
         chk($sformatf("vec%0d", k), {i.tx_slot, i.tx_en, i.rx_en, i.corr_win_open},
             {tv[k].ts, tv[k].tx, tv[k].rx, tv[k].rx});
         i.regi_link_en = 1'b0;
         step();
         chk($sformatf("vec%0d_off", k), outs() & 7'b0111111, 7'd0);
         i.regi_link_en = 1'b1;
      end
      // master TX burst of 366 us
      i.tx_req = 1'b1;
      i.regi_tx_len_us = 9'd366;
      enter(1'b1, 1'b0);
      chk("tx1_on", {i.tx_en, i.rx_en}, 2'b10);
      n_us = 0;
      gap = 0;
      for (int c = 0; c < 4000 && i.tx_en; c++) begin
         drive();
         if (i.p_1us) begin
            n_us++;
            gap = 0;
         end else gap++;
         settle();
      end
      chk("tx1_us", n_us, 366);
      chk("tx1_fall_lag", gap, 1);
      chk("tx1_off", outs(), 7'b1000000);
      // slave RX, sync inside the window, then end of packet
      i.tx_req = 1'b0;
      i.regi_is_master = 1'b0;
      i.regi_win_us = 6'd8;
      enter(1'b0, 1'b0);
      chk("rx2_open", {i.tx_slot, i.tx_en, i.rx_en, i.corr_win_open}, 4'b0011);
      run_to(70);
      drive(1'b1, 1'b0);
      exp_p(SY);
      settle();
      chk("rx2_active", {i.tx_en, i.rx_en, i.corr_win_open}, 3'b010);
      repeat (20) step();
      chk("rx2_hold", {i.tx_en, i.rx_en, i.corr_win_open}, 3'b010);
      drive(1'b0, 1'b1);
      settle();
      chk("rx2_done", outs(), 7'd0);
      // no sync: window closes at 68+8
      enter(1'b0, 1'b0);
      hit = 1'b0;
      for (int c = 0; c < 1000 && !hit; c++) begin
         drive();
         if (i.p_1us && us == 76) begin
            hit = 1'b1;
            exp_p(TO);
            chk("rx3_pre", {i.rx_en, i.corr_win_open}, 2'b11);
         end
         settle();
      end
      chk("rx3_hit", hit, 1'b1);
      chk("rx3_fall", outs() & 7'b0111101, 7'd0);
      // sync on the very cycle the window closes
      enter(1'b0, 1'b0);
      run_to(76);
      repeat (4) step();
      drive(1'b1, 1'b0);
      exp_p(SY);
      settle();
      chk("c5_active", {i.tx_en, i.rx_en, i.corr_win_open}, 3'b010);
      drive(1'b0, 1'b1);
      settle();
      chk("c5_done", outs(), 7'd0);
      // multi-slot RX with no end of packet: abort at the fifth boundary
      enter(1'b0, 1'b0);
      run_to(70);
      drive(1'b1, 1'b0);
      exp_p(SY);
      settle();
      for (int n = 1; n <= 4; n++) begin
         jump(624, 4);
         step();
         step();
      end
      chk("ab_hold", {i.tx_slot, i.tx_en, i.rx_en, i.corr_win_open}, 4'b0010);
      jump(624, 4);
      drive();
      exp_p(AB);
      settle();
      chk("ab_fall", {i.tx_en, i.rx_en}, 2'b00);
      step();
      chk("ab_decide", {i.tx_slot, i.tx_en, i.rx_en}, 3'b100);
      // link disabled in the middle of a burst
      i.tx_req = 1'b1;
      enter(1'b1, 1'b0);
      repeat (100) step();
      chk("lnk_tx", i.tx_en, 1'b1);
      i.regi_link_en = 1'b0;
      step();
      chk("lnk_off", outs() & 7'b0111111, 7'd0);
      i.regi_link_en = 1'b1;
      repeat (10) step();
      chk("lnk_idle", i.tx_en, 1'b0);
      // asynchronous reset while receiving
      i.tx_req = 1'b0;
      enter(1'b0, 1'b0);
      run_to(70);
      drive(1'b1, 1'b0);
      exp_p(SY);
      settle();
      repeat (5) step();
      chk("rst_pre", {i.rx_en, i.corr_win_open}, 2'b10);
      @(negedge clk_6M);
      #20;
      rstz = 1'b0;
      #1;
      chk("rst_async", outs(), 7'd0);
      @(negedge clk_6M);
      rstz = 1'b1;
      repeat (10) step();
      chk("rst_idle", outs(), 7'd0);
      repeat (3) step();
      chk("sb_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
